// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches a 32-bit insn, hands it to the decoder, then launches execute or halts.
// Optional feature: define ILLEGAL_TRAP_EN to redirect illegal insns to a trap vector instead of halting.
module cpu_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [63:0] PC_STEP   = 64'd4,
    parameter int unsigned FETCH_TMO = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_insn,
    input  logic        i_dec_valid,
    input  logic [3:0]  i_dec_to_state,
    output logic        o_ex_start,
    input  logic        i_ex_done,
    output logic [3:0]  o_state,
    output logic [63:0] o_pc,
    output logic        o_halted,
    output logic        o_fault
);

    // Encodings shared with the decoder's to_state field.
    typedef enum logic [3:0] {
        STATE_FETCH   = 4'd0,
        STATE_DECODE  = 4'd1,
        STATE_EXECUTE = 4'd2,
        STATE_HALT    = 4'd3
`ifdef ILLEGAL_TRAP_EN
        , STATE_TRAP  = 4'd4
`endif
    } state_t;

    localparam bit          TMO_EN   = (FETCH_TMO != 0);
    localparam logic [31:0] TMO_LAST = FETCH_TMO - 32'd1;
    localparam logic [63:0] TRAP_PC  = RESET_PC + 64'h100;

    state_t      state;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        req;
    logic        ex_start;
    logic        halted;
    logic        fault;
    logic [31:0] tmo_cnt;

    // NOTE: every register, including the insn latch, sits in one clocked block with a
    // synchronous reset, and all of it uses non-blocking assignments so each branch reads
    // the pre-edge values of the other registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= STATE_FETCH;
            pc       <= RESET_PC;
            insn     <= '0;
            req      <= 1'b0;
            ex_start <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            ex_start <= 1'b0;
            case (state)
                STATE_FETCH: begin
                    // An ack only counts while a request is actually outstanding.
                    if (req && i_imem_ack) begin
                        insn    <= i_imem_data;
                        req     <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= STATE_DECODE;
                    end else if (req) begin
                        if (TMO_EN && tmo_cnt == TMO_LAST) begin
                            req    <= 1'b0;
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= STATE_HALT;
                        end else if (TMO_EN) begin
                            tmo_cnt <= tmo_cnt + 32'd1;
                        end
                    end else begin
                        req <= 1'b1;
                    end
                end

                STATE_DECODE: begin
                    if (i_dec_valid && i_dec_to_state == STATE_HALT) begin
                        halted <= 1'b1;
                        state  <= STATE_HALT;
                    end else if (i_dec_valid && i_dec_to_state == STATE_EXECUTE) begin
                        ex_start <= 1'b1;
                        state    <= STATE_EXECUTE;
                    end else begin
                        fault <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        state <= STATE_TRAP;
`else
                        halted <= 1'b1;
                        state  <= STATE_HALT;
`endif
                    end
                end

                STATE_EXECUTE: begin
                    if (i_ex_done) begin
                        pc    <= pc + PC_STEP;
                        req   <= 1'b1;
                        state <= STATE_FETCH;
                    end
                end

`ifdef ILLEGAL_TRAP_EN
                STATE_TRAP: begin
                    pc    <= TRAP_PC;
                    req   <= 1'b1;
                    state <= STATE_FETCH;
                end
`endif

                STATE_HALT: begin
                    req    <= 1'b0;
                    halted <= 1'b1;
                end

                default: begin
                    req    <= 1'b0;
                    fault  <= 1'b1;
                    halted <= 1'b1;
                    state  <= STATE_HALT;
                end
            endcase
        end
    end

    assign o_state     = state;
    assign o_pc        = pc;
    assign o_imem_addr = pc;
    assign o_imem_req  = req;
    assign o_insn      = insn;
    assign o_ex_start  = ex_start;
    assign o_halted    = halted;
    assign o_fault     = fault;

    // Structural invariants of the registered outputs.
    a_start_in_execute: assert property (@(posedge i_clk) disable iff (i_rst)
        ex_start |-> state == STATE_EXECUTE);
    a_req_in_fetch: assert property (@(posedge i_clk) disable iff (i_rst)
        req |-> state == STATE_FETCH);
    a_halted_matches_state: assert property (@(posedge i_clk) disable iff (i_rst)
        halted == (state == STATE_HALT));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one main instance (FETCH_TMO = 5) and one for PC wrap-around.
module tb_cpu_sequencer;

    localparam logic [63:0] RP      = 64'h0000_0000_0000_1000;
    localparam logic [63:0] RP_WRAP = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [3:0]  ENC_FETCH = 4'd0;
    localparam logic [3:0]  ENC_EXEC  = 4'd2;
    localparam logic [3:0]  ENC_HALT  = 4'd3;

    // Snapshot {state, req, ex_start, halted, fault}
    localparam logic [7:0] S_F0  = 8'h00;
    localparam logic [7:0] S_F1  = 8'h08;
    localparam logic [7:0] S_DE  = 8'h10;
    localparam logic [7:0] S_EX  = 8'h24;
    localparam logic [7:0] S_EW  = 8'h20;
    localparam logic [7:0] S_HA  = 8'h32;
    localparam logic [7:0] S_HF  = 8'h33;
    localparam logic [7:0] S_TR  = 8'h41;
    localparam logic [7:0] S_F1F = 8'h09;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack;
    logic [31:0] data;
    logic        valid;
    logic [3:0]  to_state;
    logic        done;

    logic        m_req, m_start, m_halted, m_fault;
    logic [63:0] m_addr, m_pc;
    logic [31:0] m_insn;
    logic [3:0]  m_state;
    logic        w_req, w_start, w_halted, w_fault;
    logic [63:0] w_addr, w_pc;
    logic [31:0] w_insn;
    logic [3:0]  w_state;
    logic [7:0]  obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs = {m_state, m_req, m_start, m_halted, m_fault};

    cpu_sequencer #(.RESET_PC(RP), .PC_STEP(64'd4), .FETCH_TMO(5)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(m_req), .o_imem_addr(m_addr), .i_imem_ack(ack), .i_imem_data(data),
        .o_insn(m_insn), .i_dec_valid(valid), .i_dec_to_state(to_state),
        .o_ex_start(m_start), .i_ex_done(done),
        .o_state(m_state), .o_pc(m_pc), .o_halted(m_halted), .o_fault(m_fault)
    );

    cpu_sequencer #(.RESET_PC(RP_WRAP)) dut_wrap (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ack(ack), .i_imem_data(data),
        .o_insn(w_insn), .i_dec_valid(valid), .i_dec_to_state(to_state),
        .o_ex_start(w_start), .i_ex_done(done),
        .o_state(w_state), .o_pc(w_pc), .o_halted(w_halted), .o_fault(w_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ack = 1'b0; data = 32'h0; valid = 1'b0; to_state = ENC_FETCH; done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ack = 1'b1; data = 32'h1234_5678; valid = 1'b1; to_state = ENC_EXEC; done = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== S_F0) begin errors++; $display("FAIL reset_flags: got %h want %h", obs, S_F0); end
        checks++;
        if (m_pc !== RP) begin errors++; $display("FAIL reset_pc: got %h want %h", m_pc, RP); end
        checks++;
        if (m_addr !== RP) begin errors++; $display("FAIL reset_addr: got %h want %h", m_addr, RP); end
        checks++;
        if (m_insn !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h want 0", m_insn); end
        tick();
        checks++;
        if (obs !== S_F1) begin errors++; $display("FAIL reset_ack_ignored: got %h want %h", obs, S_F1); end
        checks++;
        if (m_insn !== 32'h0) begin errors++; $display("FAIL reset_insn_hold: got %h want 0", m_insn); end
    endtask

    task automatic test_halt_insn();
        logic [7:0] es [6];
        int starts = 0;
        es = '{S_F0, S_F1, S_DE, S_HA, S_HA, S_HA};
        do_reset();
        ack = 1'b1; data = 32'h0; valid = 1'b1; to_state = ENC_HALT; done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs !== es[c]) begin errors++; $display("FAIL halt_seq cyc%0d: got %h want %h", c, obs, es[c]); end
            if (m_start) starts++;
            tick();
        end
        checks++;
        if (m_pc !== RP) begin errors++; $display("FAIL halt_pc: got %h want %h", m_pc, RP); end
        checks++;
        if (starts != 0) begin errors++; $display("FAIL halt_no_start: got %0d pulses want 0", starts); end
    endtask

    task automatic test_execute();
        logic [7:0] es [17];
        logic [63:0] epc;
        logic [31:0] ein;
        int starts = 0;
        es = '{S_F0, S_F1, S_F1, S_F1, S_DE, S_EX, S_F1, S_F1, S_F1, S_DE, S_EX,
               S_F1, S_F1, S_F1, S_DE, S_EX, S_F1};
        do_reset();
        valid = 1'b1; to_state = ENC_EXEC; done = 1'b1;
        for (int c = 0; c < 17; c++) begin
            ack  = (c == 3 || c == 8 || c == 13);
            data = (c == 3) ? 32'hA000_0000 : (c == 8) ? 32'hA000_0001 :
                   (c == 13) ? 32'hA000_0002 : 32'hDEAD_BEEF;
            epc = (c <= 5) ? RP : (c <= 10) ? RP + 64'd4 : (c <= 15) ? RP + 64'd8 : RP + 64'd12;
            ein = (c <= 3) ? 32'h0 : (c <= 8) ? 32'hA000_0000 : (c <= 13) ? 32'hA000_0001 : 32'hA000_0002;
            checks++;
            if (obs !== es[c]) begin errors++; $display("FAIL exec_seq cyc%0d: got %h want %h", c, obs, es[c]); end
            checks++;
            if (m_pc !== epc) begin errors++; $display("FAIL exec_pc cyc%0d: got %h want %h", c, m_pc, epc); end
            checks++;
            if (m_insn !== ein) begin errors++; $display("FAIL exec_insn cyc%0d: got %h want %h", c, m_insn, ein); end
            if (m_start) starts++;
            tick();
        end
        checks++;
        if (starts != 3) begin errors++; $display("FAIL exec_start_count: got %0d want 3", starts); end
        checks++;
        if (m_addr !== RP + 64'd12) begin errors++; $display("FAIL exec_addr: got %h want %h", m_addr, RP + 64'd12); end
    endtask

    task automatic test_timeout();
        logic [7:0] es [8];
        es = '{S_F0, S_F1, S_F1, S_F1, S_F1, S_F1, S_HF, S_HF};
        do_reset();
        ack = 1'b0; valid = 1'b1; to_state = ENC_HALT; done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (obs !== es[c]) begin errors++; $display("FAIL tmo_seq cyc%0d: got %h want %h", c, obs, es[c]); end
            tick();
        end
        checks++;
        if (m_pc !== RP) begin errors++; $display("FAIL tmo_pc: got %h want %h", m_pc, RP); end
    endtask

    task automatic test_ack_at_timeout();
        logic [7:0] es [8];
        es = '{S_F0, S_F1, S_F1, S_F1, S_F1, S_F1, S_DE, S_HA};
        do_reset();
        valid = 1'b1; to_state = ENC_HALT; done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ack  = (c == 5);
            data = (c == 5) ? 32'hC0DE_0005 : 32'hDEAD_BEEF;
            checks++;
            if (obs !== es[c]) begin errors++; $display("FAIL tmo_ack_seq cyc%0d: got %h want %h", c, obs, es[c]); end
            if (c == 6) begin
                checks++;
                if (m_insn !== 32'hC0DE_0005) begin
                    errors++; $display("FAIL tmo_ack_insn: got %h want c0de0005", m_insn);
                end
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [7:0]  es  [6];
        logic [63:0] epc [6];
`ifdef ILLEGAL_TRAP_EN
        es  = '{S_F0, S_F1, S_DE, S_TR, S_F1F, S_F1F};
        epc = '{RP, RP, RP, RP, RP + 64'h100, RP + 64'h100};
`else
        es  = '{S_F0, S_F1, S_DE, S_HF, S_HF, S_HF};
        epc = '{RP, RP, RP, RP, RP, RP};
`endif
        for (int k = 0; k < 2; k++) begin
            do_reset();
            valid = (k == 1); to_state = (k == 0) ? ENC_EXEC : 4'hF; done = 1'b1;
            for (int c = 0; c < 6; c++) begin
                ack  = (c == 1);
                data = 32'hBAD0_0000 + 32'(k);
                checks++;
                if (obs !== es[c]) begin errors++; $display("FAIL illegal%0d_seq cyc%0d: got %h want %h", k, c, obs, es[c]); end
                checks++;
                if (m_addr !== epc[c]) begin errors++; $display("FAIL illegal%0d_addr cyc%0d: got %h want %h", k, c, m_addr, epc[c]); end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  es [12];
        logic [63:0] epc;
        logic [31:0] ein;
        es = '{S_F0, S_F1, S_DE, S_EX, S_F1, S_DE, S_EX, S_EW, S_F0, S_F1, S_F0, S_F1};
        do_reset();
        valid = 1'b1; to_state = ENC_EXEC;
        for (int c = 0; c < 12; c++) begin
            rst  = (c == 7 || c == 9);
            ack  = (c == 1 || c == 4 || c == 8);
            data = (c == 1) ? 32'h1111_0001 : (c == 4) ? 32'h2222_0002 : 32'h3333_0003;
            done = (c == 3);
            epc  = (c <= 3) ? RP : (c <= 7) ? RP + 64'd4 : RP;
            ein  = (c <= 1) ? 32'h0 : (c <= 4) ? 32'h1111_0001 : (c <= 7) ? 32'h2222_0002 : 32'h0;
            checks++;
            if (obs !== es[c]) begin errors++; $display("FAIL rstmid_seq cyc%0d: got %h want %h", c, obs, es[c]); end
            checks++;
            if (m_pc !== epc) begin errors++; $display("FAIL rstmid_pc cyc%0d: got %h want %h", c, m_pc, epc); end
            checks++;
            if (m_insn !== ein) begin errors++; $display("FAIL rstmid_insn cyc%0d: got %h want %h", c, m_insn, ein); end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        checks++;
        if (w_pc !== RP_WRAP) begin errors++; $display("FAIL wrap_reset_pc: got %h want %h", w_pc, RP_WRAP); end
        ack = 1'b1; data = 32'h0000_0013; valid = 1'b1; to_state = ENC_EXEC; done = 1'b1;
        repeat (4) tick();
        checks++;
        if (w_pc !== 64'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", w_pc); end
        checks++;
        if (w_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", w_addr); end
        checks++;
        if ({w_state, w_req, w_start, w_halted, w_fault} !== S_F1) begin
            errors++; $display("FAIL wrap_flags: got %h want %h", {w_state, w_req, w_start, w_halted, w_fault}, S_F1);
        end
        checks++;
        if (m_pc !== RP + 64'd4) begin errors++; $display("FAIL wrap_main_pc: got %h want %h", m_pc, RP + 64'd4); end
    endtask

    initial begin
        test_reset();
        test_halt_insn();
        test_execute();
        test_timeout();
        test_ack_at_timeout();
        test_illegal();
        test_reset_mid();
        test_pc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
